fft_peak_detector: RTL and testbench
====================================

// Module: fft_peak_detector
// PURPOSE
//  Downstream of the 64-point FFT (fft_64) in the pitch game. Consumes the FFT
//  Avalon-ST output, forms |re|+|im| per bin, finds the loudest bin in a search
//  band and maps it to the bird's vertical position (bird_y) for position/collision.
//  Holds position while input is below a loudness threshold.
// PARAMETERS
//  NPTS       64    FFT frame length in beats (bins 0..NPTS-1)
//  DATA_W     19    width of source_real/source_imag (signed two's complement)
//  BIN_LO     1     lowest bin searched (inclusive)
//  BIN_HI     31    highest bin searched (inclusive, BIN_LO<=BIN_HI<NPTS)
//  MAG_THRESH 1000  minimum peak magnitude treated as a voiced pitch
//  Y_BOT      440   bird_y for bin BIN_LO (low pitch = low on screen)
//  Y_STEP     14    pixels per bin; bird_y = Y_BOT - (bin-BIN_LO)*Y_STEP
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  source_valid  in   1       FFT output beat valid
//  source_ready  out  1       ready to FFT; 0 during reset, 1 otherwise
//  source_sop    in   1       first beat of frame (bin 0)
//  source_eop    in   1       last beat of frame (bin NPTS-1)
//  source_error  in   2       FFT error code; nonzero poisons the frame
//  source_real   in   DATA_W  bin real part, signed
//  source_imag   in   DATA_W  bin imaginary part, signed
//  peak_bin      out  6       index of loudest in-band bin of last voiced frame
//  peak_mag      out  DATA_W+1 magnitude of that bin, unsigned
//  peak_valid    out  1       1-cycle pulse: a frame was accepted and evaluated
//  silent        out  1       1 = last accepted frame peak < MAG_THRESH
//  bird_y        out  10      vertical bird centre for game logic
//  frame_error   out  1       1-cycle pulse: malformed or poisoned frame dropped
// BEHAVIOUR
//  Reset values: peak_bin=0, peak_mag=0, peak_valid=0, silent=1, bird_y=Y_BOT,
//   frame_error=0, state=IDLE, bin counter=0, running max cleared.
//  Beat accepted when source_valid & source_ready; gaps in valid stall nothing.
//  Magnitude: |re|+|im| in DATA_W+1 bits unsigned; |-2^(DATA_W-1)| = 2^(DATA_W-1), no overflow.
//  FSM IDLE: accepted beat with sop -> ACCUM, cnt=1, process bin 0; beats without sop ignored.
//  FSM ACCUM: each accepted beat processes bin cnt, cnt++.
//   - bin in [BIN_LO,BIN_HI] and mag > running max (strict) -> max,bin updated;
//     ties keep the lower bin.
//   - sop mid-frame: discard partial frame, frame_error pulse, restart with this beat as bin 0.
//   - eop with cnt != NPTS-1, or cnt == NPTS-1 without eop: frame_error pulse, -> IDLE.
//   - sop and eop on same beat: error, -> IDLE.
//   - any nonzero source_error in frame: frame marked bad; at eop frame_error, -> IDLE.
//   - good eop -> REPORT.
//  FSM REPORT (one cycle, then IDLE): peak_valid=1. If max >= MAG_THRESH: peak_bin,
//   peak_mag, bird_y updated, silent=0; else silent=1, peak_bin/peak_mag/bird_y held.
//  Latency: peak_valid and updated outputs visible the cycle after the good eop beat.
//  A sop beat arriving during REPORT is ignored (source_ready stays 1; beat lost).
//  Reset mid-frame: partial frame discarded, all outputs to reset values next cycle.
// CONFIGURATION
//  PEAK_SMOOTH_EN defined: on voiced REPORT bird_y <= (bird_y + y_new) >> 1
//   (11-bit sum, truncating) to damp jitter. Undefined: bird_y <= y_new directly.
// TESTING (defaults, smoothing off unless stated)
//  1 Frame all zero except bin 10 re=5000 im=-3000 -> cycle after eop: peak_valid=1,
//    peak_bin=10, peak_mag=8000, bird_y=314, silent=0.
//  2 Bins 5 and 20 both mag 2000 -> peak_bin=5, bird_y=384.
//  3 All bins mag 500 after test 1 -> peak_valid=1, silent=1, bird_y=314, peak_bin=10 held.
//  4 Bin 40 mag 50000, bin 3 mag 1500 -> peak_bin=3, bird_y=412 (out-of-band ignored).
//  5 eop on beat 31; then frame with source_error=1 on bin 7 -> frame_error pulse each,
//    no peak_valid; following good frame reports normally.
//  6 reset at beat 20 with random valid gaps -> reset values; next frame as test 1;
//    with PEAK_SMOOTH_EN from reset: bird_y=(440+314)>>1=377.

Source files
------------

// File: rtl/fft_peak_detector.sv
// fft_peak_detector
//   Sits behind the 64-point FFT in the pitch game. For every Avalon-ST output
//   frame it forms |re|+|im| per bin and finds the loudest bin inside
//   [BIN_LO,BIN_HI]. It then maps that bin to the bird's vertical position.
//   Frames whose peak is below MAG_THRESH are reported as silent, and the bird
//   holds its position for those frames.
//
//   Optional feature: define PEAK_SMOOTH_EN to average each new position with
//   the previous one. This damps jitter in the bird's movement.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   source_valid        FFT beat valid
//   source_ready        ready to FFT (low only while reset is high)
//   source_sop/eop      first / last beat of a frame
//   source_error[1:0]   FFT error code; any nonzero value poisons the frame
//   source_real/imag    signed bin value
//   peak_bin, peak_mag  loudest in-band bin of the last voiced frame, and its magnitude
//   peak_valid          1-cycle pulse, asserted when a frame has been evaluated
//   silent              last evaluated frame was below threshold
//   bird_y              vertical bird centre
//   frame_error         1-cycle pulse, asserted when a malformed or poisoned frame is dropped
module fft_peak_detector #(
   parameter int NPTS       = 64,
   parameter int DATA_W     = 19,
   parameter int BIN_LO     = 1,
   parameter int BIN_HI     = 31,
   parameter int MAG_THRESH = 1000,
   parameter int Y_BOT      = 440,
   parameter int Y_STEP     = 14
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     source_valid,
   output logic                     source_ready,
   input  logic                     source_sop,
   input  logic                     source_eop,
   input  logic [1:0]               source_error,
   input  logic signed [DATA_W-1:0] source_real,
   input  logic signed [DATA_W-1:0] source_imag,
   output logic [5:0]               peak_bin,
   output logic [DATA_W:0]          peak_mag,
   output logic                     peak_valid,
   output logic                     silent,
   output logic [9:0]               bird_y,
   output logic                     frame_error
);
   localparam int CW = $clog2(NPTS);
   localparam int MW = DATA_W + 1;
   localparam logic [CW-1:0] LAST = CW'(NPTS - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [MW-1:0]  max_q, max_nxt;
   logic [CW-1:0]  bin_q, bin_nxt, cur_bin;
   logic           bad_q, bad_nxt;
   logic           beat, has_err, start, take, in_band, err_evt, rpt_evt;
   logic [DATA_W-1:0] re_abs, im_abs;
   logic [MW-1:0]  mag;
   logic [9:0]     y_new;

   assign beat    = source_valid & source_ready;
   assign has_err = |source_error;

   // Two's-complement negate. The most negative input gives 100..0, which is
   // the correct magnitude when read as unsigned, so no saturation is needed.
   assign re_abs = source_real[DATA_W-1] ? (~source_real + 1'b1) : source_real;
   assign im_abs = source_imag[DATA_W-1] ? (~source_imag + 1'b1) : source_imag;
   assign mag    = {1'b0, re_abs} + {1'b0, im_abs};

   // Position of the peak as it will stand once the current beat is folded in.
   assign y_new = 10'(Y_BOT - (int'(bin_nxt) - BIN_LO) * Y_STEP);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and frame bookkeeping
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      max_nxt   = max_q;
      bin_nxt   = bin_q;
      bad_nxt   = bad_q;
      err_evt   = 1'b0;
      rpt_evt   = 1'b0;
      start     = 1'b0;
      take      = 1'b0;
      case (state)
         IDLE: if (beat && source_sop) begin
            if (source_eop) err_evt = 1'b1;
            else            start   = 1'b1;
         end
         ACCUM: if (beat) begin
            if (source_sop) begin
               // A new frame started early: drop the partial frame and restart.
               err_evt = 1'b1;
               if (source_eop) state_nxt = IDLE;
               else            start     = 1'b1;
            end else if (source_eop != (cnt == LAST)) begin
               err_evt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               take    = 1'b1;
               cnt_nxt = cnt + 1'b1;
               bad_nxt = bad_q | has_err;
               if (source_eop) begin
                  if (bad_nxt) begin
                     err_evt   = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     rpt_evt   = 1'b1;
                     state_nxt = REPORT;
                  end
               end
            end
         end
         REPORT:  state_nxt = IDLE;   // beats arriving here are dropped
         default: state_nxt = IDLE;
      endcase
      if (start) begin
         state_nxt = ACCUM;
         cnt_nxt   = CW'(1);
         bad_nxt   = has_err;
         max_nxt   = '0;
         bin_nxt   = '0;
         take      = 1'b1;
      end
      cur_bin = start ? '0 : cnt;
      in_band = (int'(cur_bin) >= BIN_LO) && (int'(cur_bin) <= BIN_HI);
      // Strict compare means that on a tie the lower bin is kept.
      if (take && in_band && (mag > max_nxt)) begin
         max_nxt = mag;
         bin_nxt = cur_bin;
      end
   end

   // Outputs decoded from state
   always_comb begin
      source_ready = ~reset;
      peak_valid   = (state == REPORT);
   end

   // Datapath and result registers. Results are loaded on the good-eop edge,
   // so they become visible together with peak_valid.
`ifdef PEAK_SMOOTH_EN
   logic [10:0] y_sum;
   assign y_sum = {1'b0, bird_y} + {1'b0, y_new};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         max_q       <= '0;
         bin_q       <= '0;
         bad_q       <= 1'b0;
         peak_bin    <= '0;
         peak_mag    <= '0;
         silent      <= 1'b1;
         bird_y      <= 10'(Y_BOT);
         frame_error <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         max_q       <= max_nxt;
         bin_q       <= bin_nxt;
         bad_q       <= bad_nxt;
         frame_error <= err_evt;
         if (rpt_evt) begin
            if (max_nxt >= MW'(MAG_THRESH)) begin
               peak_bin <= 6'(bin_nxt);
               peak_mag <= max_nxt;
               silent   <= 1'b0;
`ifdef PEAK_SMOOTH_EN
               bird_y   <= y_sum[10:1];
`else
               bird_y   <= y_new;
`endif
            end else begin
               silent   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fft_peak_detector.sv
// Testbench for fft_peak_detector: directed frames plus randomized frames,
// checked against a frame-level reference model.
module tb_fft_peak_detector;
   localparam int NPTS = 64, DW = 19, BIN_LO = 1, BIN_HI = 31;
   localparam int THR = 1000, Y_BOT = 440, Y_STEP = 14;

   logic clk = 1'b0, reset = 1'b1;
   logic source_valid = 1'b0, source_sop = 1'b0, source_eop = 1'b0;
   logic [1:0] source_error = '0;
   logic signed [DW-1:0] source_real = '0, source_imag = '0;
   logic source_ready, peak_valid, silent, frame_error;
   logic [5:0] peak_bin;
   logic [DW:0] peak_mag;
   logic [9:0] bird_y;

   fft_peak_detector dut (
      .clk(clk), .reset(reset), .source_valid(source_valid), .source_ready(source_ready),
      .source_sop(source_sop), .source_eop(source_eop), .source_error(source_error),
      .source_real(source_real), .source_imag(source_imag), .peak_bin(peak_bin),
      .peak_mag(peak_mag), .peak_valid(peak_valid), .silent(silent), .bird_y(bird_y),
      .frame_error(frame_error));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, pv_cnt = 0, fe_cnt = 0;
   int fr_re[NPTS], fr_im[NPTS], fr_err[NPTS];
   int m_bin, m_mag, m_silent, m_y;

   always @(negedge clk) begin
      pv_cnt <= pv_cnt + int'(peak_valid);
      fe_cnt <= fe_cnt + int'(frame_error);
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      m_bin = 0; m_mag = 0; m_silent = 1; m_y = Y_BOT;
   endtask

   // Evaluate a complete good frame held in fr_re/fr_im.
   task automatic model_frame();
      int best, bb, ynew;
      best = 0; bb = 0;
      for (int b = BIN_LO; b <= BIN_HI; b++)
         if (iabs(fr_re[b]) + iabs(fr_im[b]) > best) begin
            best = iabs(fr_re[b]) + iabs(fr_im[b]);
            bb = b;
         end
      if (best >= THR) begin
         ynew = Y_BOT - (bb - BIN_LO) * Y_STEP;
         m_bin = bb; m_mag = best; m_silent = 0;
`ifdef PEAK_SMOOTH_EN
         m_y = (m_y + ynew) / 2;
`else
         m_y = ynew;
`endif
      end else m_silent = 1;
   endtask

   task automatic clr();
      for (int b = 0; b < NPTS; b++) begin fr_re[b] = 0; fr_im[b] = 0; fr_err[b] = 0; end
   endtask

   task automatic idle();
      @(negedge clk);
      source_valid = 1'b0;
      source_sop = 1'($urandom); source_eop = 1'($urandom);
      source_real = DW'($urandom); source_imag = DW'($urandom);
   endtask

   task automatic drive_beat(input int b, input bit sop, input bit eop);
      source_valid = 1'b1; source_sop = sop; source_eop = eop;
      source_error = 2'(fr_err[b]);
      source_real = fr_re[b][DW-1:0]; source_imag = fr_im[b][DW-1:0];
   endtask

   task automatic beat(input int b, input bit sop, input bit eop, input bit gaps);
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      @(negedge clk);
      drive_beat(b, sop, eop);
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".bin"}, peak_bin, m_bin);
      chk({tag, ".mag"}, peak_mag, m_mag);
      chk({tag, ".silent"}, silent, m_silent);
      chk({tag, ".y"}, bird_y, m_y);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".pv"}, peak_valid, 0);
      chk({tag, ".fe"}, frame_error, 0);
      model_reset();
      check_outputs(tag);
   endtask

   // Optional partial frame (pre_n beats), then n beats with sop on beat 0
   // and eop on beat eop_at. Checks the pulses the cycle after the last beat.
   task automatic run(input string tag, input int pre_n, input int n, input int eop_at,
                      input int exp_pv, input int exp_fe);
      int p0, f0;
      p0 = pv_cnt; f0 = fe_cnt;
      for (int b = 0; b < pre_n; b++) beat(b, b == 0, 1'b0, 1'b1);
      for (int b = 0; b < n; b++) beat(b, b == 0, b == eop_at, 1'b1);
      @(negedge clk);
      chk({tag, ".pv_t"}, peak_valid, exp_pv);
      chk({tag, ".fe_t"}, frame_error, exp_fe);
      source_valid = 1'b0;
      if (exp_pv != 0) model_frame();
      repeat (3) @(negedge clk);
      chk({tag, ".pv_n"}, pv_cnt - p0, exp_pv);
      chk({tag, ".fe_n"}, fe_cnt - f0, exp_fe + ((pre_n > 0) ? 1 : 0));
      check_outputs(tag);
   endtask

   initial begin
      int p0, f0;
      logic signed [DW-1:0] r;
      model_reset();
      clr();
      repeat (3) @(negedge clk);
      chk("rst.ready", source_ready, 0);
      check_reset("rst");
      reset = 1'b0;
      #1 chk("ready", source_ready, 1);

      // Single loud bin
      clr(); fr_re[10] = 5000; fr_im[10] = -3000;
      run("t1", 0, NPTS, NPTS - 1, 1, 0);
      // Everything below threshold: the previous position is held
      for (int b = 0; b < NPTS; b++) begin fr_re[b] = 300; fr_im[b] = -200; end
      run("t3", 0, NPTS, NPTS - 1, 1, 0);
      // Tie between two bins: the lower bin wins
      clr(); fr_re[5] = 2000; fr_im[20] = -2000;
      run("t2", 0, NPTS, NPTS - 1, 1, 0);
      // A loud out-of-band bin is ignored
      clr(); fr_re[40] = 50000; fr_re[3] = 1000; fr_im[3] = 500;
      run("t4", 0, NPTS, NPTS - 1, 1, 0);
      // Most negative values give the full magnitude, with no overflow
      clr(); fr_re[12] = -262144; fr_im[12] = -262144;
      run("neg", 0, NPTS, NPTS - 1, 1, 0);
      // Malformed frames
      clr(); fr_re[8] = 9000;
      run("e31", 0, 32, 31, 0, 1);
      run("noeop", 0, NPTS, -1, 0, 1);
      run("sopeop", 0, 1, 0, 0, 1);
      fr_err[7] = 1;
      run("perr", 0, NPTS, NPTS - 1, 0, 1);
      fr_err[7] = 0;
      run("good", 0, NPTS, NPTS - 1, 1, 0);
      // A sop arriving mid-frame restarts the frame
      clr(); fr_re[25] = -7000;
      run("restart", 10, NPTS, NPTS - 1, 1, 0);

      // A sop beat during REPORT is lost, so the rest of that frame is ignored
      clr(); fr_im[15] = 4000;
      p0 = pv_cnt; f0 = fe_cnt;
      for (int b = 0; b < NPTS; b++) beat(b, b == 0, b == NPTS - 1, 1'b0);
      @(negedge clk);
      chk("rpt.pv_t", peak_valid, 1);
      model_frame();
      fr_re[2] = 20000;
      drive_beat(0, 1'b1, 1'b0);
      for (int b = 1; b < NPTS; b++) beat(b, 1'b0, b == NPTS - 1, 1'b1);
      @(negedge clk);
      source_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rpt.pv_n", pv_cnt - p0, 1);
      chk("rpt.fe_n", fe_cnt - f0, 0);
      check_outputs("rpt");

      // Reset in the middle of a frame
      clr(); fr_re[10] = 5000; fr_im[10] = -3000;
      for (int b = 0; b < 20; b++) beat(b, b == 0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("mrst.ready", source_ready, 0);
      @(negedge clk);
      check_reset("mrst");
      reset = 1'b0;
      source_valid = 1'b0;
      run("t6", 0, NPTS, NPTS - 1, 1, 0);

      // Randomized frames
      for (int it = 0; it < 24; it++) begin
         int bad;
         clr();
         for (int b = 0; b < NPTS; b++) begin
            fr_re[b] = int'($urandom_range(0, 600)) - 300;
            fr_im[b] = int'($urandom_range(0, 400)) - 200;
         end
         repeat ($urandom_range(0, 3)) begin
            int k;
            k = int'($urandom_range(0, NPTS - 1));
            r = DW'($urandom); fr_re[k] = int'(r);
            r = DW'($urandom); fr_im[k] = int'(r);
            if ($urandom_range(0, 3) == 0) begin
               fr_re[(k + 3) % NPTS] = fr_re[k]; fr_im[(k + 3) % NPTS] = fr_im[k];
            end
         end
         bad = ($urandom_range(0, 4) == 0) ? 1 : 0;
         if (bad != 0) fr_err[$urandom_range(0, NPTS - 1)] = int'($urandom_range(1, 3));
         run($sformatf("rnd%0d", it), 0, NPTS, NPTS - 1, 1 - bad, bad);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
